// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle ALU between two requesters.
//
// Round-robin arbitration over two valid/ready request channels. Each
// accepted request has its ALUControl code and operands registered. The
// ALU evaluates the registered operands in EXEC. The registered result is
// then presented on the shared response bus until the granted requester
// accepts it.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   req_valid    [1:0]        per-requester request valid
//   req_ready    [1:0]        per-requester accept (one-hot or zero, IDLE only)
//   req_ctrl0/1  [CTRL_W-1:0] requester ALUControl code
//   req_a0/1     [WIDTH-1:0]  requester operand A
//   req_b0/1     [WIDTH-1:0]  requester operand B
//   rsp_valid    [1:0]        per-requester response valid (one-hot or zero)
//   rsp_ready    [1:0]        per-requester response accept
//   rsp_result   [WIDTH-1:0]  registered result of the granted op
//   rsp_zero                  registered zero flag of the granted op
//   rsp_err                   op code was illegal, result forced to 0
//   busy                      high whenever the FSM is not IDLE

// Single-cycle datapath ALU. Illegal codes produce 0; the arbiter
// overrides the outputs for those codes anyway.
module alu #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic [CTRL_W-1:0] alu_control,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic [WIDTH-1:0]  result,
  output logic              zero_flag
);

  localparam logic [CTRL_W-1:0] OP_AND = CTRL_W'(0);
  localparam logic [CTRL_W-1:0] OP_OR  = CTRL_W'(1);
  localparam logic [CTRL_W-1:0] OP_ADD = CTRL_W'(2);
  localparam logic [CTRL_W-1:0] OP_SUB = CTRL_W'(6);
  localparam logic [CTRL_W-1:0] OP_SLT = CTRL_W'(7);

  always_comb begin
    result = '0;
    case (alu_control)
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLT:  result = ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
      default: result = '0;
    endcase
  end

  assign zero_flag = (result == '0);

endmodule

module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [CTRL_W-1:0] req_ctrl0,
  input  logic [CTRL_W-1:0] req_ctrl1,
  input  logic [WIDTH-1:0]  req_a0,
  input  logic [WIDTH-1:0]  req_a1,
  input  logic [WIDTH-1:0]  req_b0,
  input  logic [WIDTH-1:0]  req_b1,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic              ptr;
  logic              grant_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;

  logic              grant_any;
  logic              grant_sel;
  logic              rsp_done;
  logic              ctrl_illegal;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_zero;

  // The ALU only ever sees the registered operands, so requesters may change
  // their inputs freely once accepted.
  alu #(.WIDTH(WIDTH), .CTRL_W(CTRL_W)) u_alu (
    .alu_control (ctrl_q),
    .a           (a_q),
    .b           (b_q),
    .result      (alu_result),
    .zero_flag   (alu_zero)
  );

  assign ctrl_illegal = !(ctrl_q inside {CTRL_W'(0), CTRL_W'(1), CTRL_W'(2),
                                         CTRL_W'(6), CTRL_W'(7)});

  // Grant decision. It is gated by rst_n so that req_ready reads zero while
  // reset is held, even though the FSM already sits in IDLE.
  always_comb begin
    grant_any = 1'b0;
    grant_sel = 1'b0;
    if (state == IDLE && rst_n) begin
      case (req_valid)
        2'b01: begin grant_any = 1'b1; grant_sel = 1'b0; end
        2'b10: begin grant_any = 1'b1; grant_sel = 1'b1; end
        2'b11: begin grant_any = 1'b1; grant_sel = ptr;  end
        default: ;
      endcase
    end
  end

  assign req_ready = grant_any ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;
  // Only the granted requester's rsp_ready completes the response.
  assign rsp_done  = (state == RESP) && rsp_ready[grant_q];
  assign rsp_valid = (state == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_any) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The pointer moves only when a response completes. Back-to-back
  // contention therefore alternates, and a lone requester never takes
  // priority away from the other.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      ptr        <= 1'b0;
      grant_q    <= 1'b0;
      ctrl_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_any) begin
        grant_q <= grant_sel;
        ctrl_q  <= grant_sel ? req_ctrl1 : req_ctrl0;
        a_q     <= grant_sel ? req_a1 : req_a0;
        b_q     <= grant_sel ? req_b1 : req_b0;
      end
      if (state == EXEC) begin
        rsp_result <= ctrl_illegal ? '0   : alu_result;
        rsp_zero   <= ctrl_illegal ? 1'b1 : alu_zero;
        rsp_err    <= ctrl_illegal;
      end
      if (rsp_done) ptr <= ~grant_q;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter.
// The reference model computes results with plain arithmetic from the op
// code. It tracks round-robin priority as "the requester that was not
// served last".
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [2:0]  req_ctrl0 = '0, req_ctrl1 = '0;
  logic [31:0] req_a0 = '0, req_a1 = '0, req_b0 = '0, req_b1 = '0;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = 2'b00;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_err, busy;

  int nvec = 0;
  int nmis = 0;
  int mptr = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .busy(busy)
  );

  typedef struct packed {
    logic [1:0] rr;
    logic [1:0] exec_v;
    logic [1:0] resp_v;
    logic       busy_idle;
    logic       busy_exec;
    logic       busy_resp;
    logic [1:0] after_v;
    logic       stall_bad;
  } hs_t;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        err;
  } rsp_t;

  function automatic rsp_t ref_alu(logic [2:0] c, logic [31:0] a, logic [31:0] b);
    rsp_t r;
    r.err = 1'b0;
    case (c)
      3'd0: r.result = a & b;
      3'd1: r.result = a | b;
      3'd2: r.result = a + b;
      3'd6: r.result = a - b;
      3'd7: r.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin r.result = 32'd0; r.err = 1'b1; end
    endcase
    r.zero = (r.result == 32'd0);
    return r;
  endfunction

  function automatic hs_t ref_hs(int g);
    hs_t h;
    logic [1:0] m;
    m = (g == 1) ? 2'b10 : 2'b01;
    h.rr = m; h.exec_v = 2'b00; h.resp_v = m;
    h.busy_idle = 1'b0; h.busy_exec = 1'b1; h.busy_resp = 1'b1;
    h.after_v = 2'b00; h.stall_bad = 1'b0;
    return h;
  endfunction

  function automatic int ref_grant(logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return mptr;
  endfunction

  task automatic set_req(input int k, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    if (k == 0) begin req_ctrl0 = c; req_a0 = a; req_b0 = b; end
    else begin req_ctrl1 = c; req_a1 = a; req_b1 = b; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mptr = 0;
  endtask

  // Drives one transaction from IDLE to completion. Entered at posedge+1
  // with requests already applied, and returns at posedge+1 of the next
  // IDLE cycle. It records what the DUT showed at each stage. The caller
  // compares those observations against the model.
  task automatic run_op(input int eg, input int stall, output hs_t h, output rsp_t r);
    logic [1:0] egm;
    egm = (eg == 1) ? 2'b10 : 2'b01;
    #1;
    h.rr = req_ready; h.busy_idle = busy;
    @(posedge clk); #1;
    req_valid = 2'b00;
    req_ctrl0 = 3'($urandom); req_ctrl1 = 3'($urandom);
    req_a0 = $urandom; req_a1 = $urandom; req_b0 = $urandom; req_b1 = $urandom;
    #1;
    h.exec_v = rsp_valid; h.busy_exec = busy;
    @(posedge clk); #1;
    rsp_ready = 2'($urandom) & ~egm;
    req_valid = 2'($urandom);
    #1;
    h.resp_v = rsp_valid; h.busy_resp = busy;
    r = {rsp_result, rsp_zero, rsp_err};
    h.stall_bad = (req_ready !== 2'b00);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      rsp_ready = 2'($urandom) & ~egm;
      req_valid = 2'($urandom);
      #1;
      if (rsp_valid !== h.resp_v || {rsp_result, rsp_zero, rsp_err} !== r ||
          req_ready !== 2'b00 || busy !== 1'b1)
        h.stall_bad = 1'b1;
    end
    rsp_ready = egm;
    req_valid = 2'b00;
    @(posedge clk); #1;
    h.after_v = rsp_valid;
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset();
    logic [38:0] obs;
    rst_n = 1'b0;
    req_valid = 2'b11;
    set_req(0, 3'd2, $urandom, $urandom);
    set_req(1, 3'd1, $urandom, $urandom);
    rsp_ready = 2'b11;
    repeat (3) @(posedge clk);
    #2;
    obs = {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, busy};
    nvec++;
    if (obs !== 39'd0) begin
      nmis++;
      $display("[TB] FAIL reset_outputs got=%h want=0", obs);
    end
    do_reset();
  endtask

  task automatic test_single_op();
    hs_t h, eh;
    rsp_t r, er;
    set_req(0, 3'd2, 32'h13256189, 32'h1325618A);
    req_valid = 2'b01;
    run_op(0, 0, h, r);
    mptr = 1;
    eh = ref_hs(0);
    er = {32'h264AC313, 1'b0, 1'b0};
    nvec++;
    if (h !== eh) begin nmis++; $display("[TB] FAIL single_handshake got=%h want=%h", h, eh); end
    nvec++;
    if (r !== er) begin nmis++; $display("[TB] FAIL single_result got=%h want=%h", r, er); end
  endtask

  task automatic test_contention();
    hs_t h, eh;
    rsp_t r, er;
    int g;
    logic [2:0] ops [5] = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd7};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i == 0 || i == 1) begin
        set_req(0, 3'd6, 32'h5, 32'h5);
        set_req(1, 3'd1, 32'hF0, 32'h0F);
      end else begin
        set_req(0, ops[$urandom_range(0, 4)], $urandom, $urandom);
        set_req(1, ops[$urandom_range(0, 4)], $urandom, $urandom);
      end
      req_valid = 2'b11;
      g = ref_grant(2'b11);
      er = (g == 0) ? ref_alu(req_ctrl0, req_a0, req_b0) : ref_alu(req_ctrl1, req_a1, req_b1);
      run_op(g, 0, h, r);
      eh = ref_hs(i % 2);
      mptr = 1 - g;
      nvec++;
      if (h !== eh) begin nmis++; $display("[TB] FAIL contention_%0d_grant got=%h want=%h", i, h, eh); end
      nvec++;
      if (r !== er) begin nmis++; $display("[TB] FAIL contention_%0d_result got=%h want=%h", i, r, er); end
    end
  endtask

  task automatic test_slt_illegal();
    hs_t h, eh;
    rsp_t r, er;
    logic [2:0]  c  [4] = '{3'd7, 3'd7, 3'd5, 3'd0};
    logic [31:0] a  [4] = '{32'hFFFFFFFF, 32'h1325618A, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] b  [4] = '{32'h00000001, 32'h13256189, 32'hFFFFFFFF, 32'hFFFFFFFF};
    rsp_t        ex [4] = '{{32'd1, 1'b0, 1'b0}, {32'd0, 1'b1, 1'b0},
                            {32'd0, 1'b1, 1'b1}, {32'hFFFFFFFF, 1'b0, 1'b0}};
    for (int i = 0; i < 4; i++) begin
      set_req(0, c[i], a[i], b[i]);
      req_valid = 2'b01;
      run_op(0, 0, h, r);
      mptr = 1;
      eh = ref_hs(0);
      er = ex[i];
      nvec++;
      if (h !== eh) begin nmis++; $display("[TB] FAIL slt_illegal_%0d_hs got=%h want=%h", i, h, eh); end
      nvec++;
      if (r !== er) begin nmis++; $display("[TB] FAIL slt_illegal_%0d_result got=%h want=%h", i, r, er); end
    end
  endtask

  task automatic test_backpressure();
    hs_t h, eh;
    rsp_t r, er;
    do_reset();
    set_req(1, 3'd2, 32'h100, 32'h23);
    req_valid = 2'b10;
    run_op(1, 10, h, r);
    mptr = 0;
    eh = ref_hs(1);
    er = {32'h123, 1'b0, 1'b0};
    nvec++;
    if (h !== eh) begin nmis++; $display("[TB] FAIL backpressure_hs got=%h want=%h", h, eh); end
    nvec++;
    if (r !== er) begin nmis++; $display("[TB] FAIL backpressure_result got=%h want=%h", r, er); end
    set_req(0, 3'd0, 32'hF0F0F0F0, 32'hFF00FF00);
    req_valid = 2'b01;
    run_op(0, 0, h, r);
    mptr = 1;
    eh = ref_hs(0);
    er = {32'hF000F000, 1'b0, 1'b0};
    nvec++;
    if (h !== eh) begin nmis++; $display("[TB] FAIL after_release_hs got=%h want=%h", h, eh); end
    nvec++;
    if (r !== er) begin nmis++; $display("[TB] FAIL after_release_result got=%h want=%h", r, er); end
  endtask

  task automatic test_reset_mid_op();
    hs_t h;
    rsp_t r;
    logic [38:0] obs;
    logic        pulse;
    for (int phase = 0; phase < 2; phase++) begin
      do_reset();
      set_req(0, 3'd1, 32'hA5A5A5A5, 32'h0);
      req_valid = 2'b01;
      run_op(0, 0, h, r);
      mptr = 1;
      set_req(0, 3'd2, 32'h11, 32'h22);
      set_req(1, 3'd2, 32'h33, 32'h44);
      req_valid = 2'b11;
      #1;
      nvec++;
      if (req_ready !== 2'b10) begin nmis++; $display("[TB] FAIL midreset_%0d_pregrant got=%b want=10", phase, req_ready); end
      @(posedge clk); #1;
      req_valid = 2'b00;
      if (phase == 1) begin
        @(posedge clk); #1;
      end
      rst_n = 1'b0;
      rsp_ready = 2'b11;
      @(posedge clk); #1;
      obs = {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err, busy};
      nvec++;
      if (obs !== 39'd0) begin nmis++; $display("[TB] FAIL midreset_%0d_outputs got=%h want=0", phase, obs); end
      rst_n = 1'b1;
      mptr = 0;
      pulse = 1'b0;
      repeat (3) begin
        @(posedge clk); #1;
        if (rsp_valid !== 2'b00 || busy !== 1'b0) pulse = 1'b1;
      end
      rsp_ready = 2'b00;
      nvec++;
      if (pulse !== 1'b0) begin nmis++; $display("[TB] FAIL midreset_%0d_no_response got=%b want=0", phase, pulse); end
      req_valid = 2'b11;
      #1;
      nvec++;
      if (req_ready !== 2'b01) begin nmis++; $display("[TB] FAIL midreset_%0d_first_grant got=%b want=01", phase, req_ready); end
      run_op(0, 0, h, r);
      mptr = 1;
    end
  endtask

  task automatic test_random();
    hs_t h, eh;
    rsp_t r, er;
    logic [1:0] v;
    int g;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      set_req(0, 3'($urandom), $urandom, $urandom);
      set_req(1, 3'($urandom), $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) req_a0 = req_b0;
      if ($urandom_range(0, 3) == 0) req_b1 = req_a1;
      v = 2'($urandom_range(1, 3));
      req_valid = v;
      g = ref_grant(v);
      er = (g == 0) ? ref_alu(req_ctrl0, req_a0, req_b0) : ref_alu(req_ctrl1, req_a1, req_b1);
      run_op(g, $urandom_range(0, 3), h, r);
      eh = ref_hs(g);
      mptr = 1 - g;
      nvec++;
      if (h !== eh) begin nmis++; $display("[TB] FAIL random_%0d_hs got=%h want=%h", i, h, eh); end
      nvec++;
      if (r !== er) begin nmis++; $display("[TB] FAIL random_%0d_result got=%h want=%h", i, r, er); end
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_contention();
    test_slt_illegal();
    test_backpressure();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
